// File: rtl/timer_pkg.sv
// timer_pkg: shared types, widths and wrap helpers for the countdown timer
// controller (timer_ctrl) and its mm:ss register pair (timer_mmss_cnt).
package timer_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } timer_state_t;

  localparam int MIN_W       = 7;
  localparam int SEC_W       = 6;
  localparam int ALARM_CNT_W = 8;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  // Seconds increment used while setting the time: 59 wraps to 0, no carry.
  function automatic logic [SEC_W-1:0] sec_inc_wrap(input logic [SEC_W-1:0] s);
    if (s == SEC_MAX) begin
      return '0;
    end
    return s + 1'b1;
  endfunction

  // Minutes increment used while setting the time: m_max wraps to 0.
  function automatic logic [MIN_W-1:0] min_inc_wrap(input logic [MIN_W-1:0] m,
                                                    input logic [MIN_W-1:0] m_max);
    if (m == m_max) begin
      return '0;
    end
    return m + 1'b1;
  endfunction

endpackage

// File: rtl/timer_mmss_cnt.sv
// timer_mmss_cnt: the mm:ss register pair behind the countdown timer.
// Owns the setting wrap (minutes and seconds wrap independently) and the
// countdown borrow (x:00 -> (x-1):59). The zero flag looks at the value being
// loaded this cycle, so the controller can leave RUN on the same edge that
// the count reaches 00:00.
module timer_mmss_cnt
  import timer_pkg::*;
#(
  parameter int MAX_MIN = 99
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             load_zero,
  input  logic             inc_min,
  input  logic             inc_sec,
  input  logic             dec,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic             zero
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);

  logic [MIN_W-1:0] min_q;
  logic [SEC_W-1:0] sec_q;
  logic [MIN_W-1:0] min_nxt;
  logic [SEC_W-1:0] sec_nxt;

  // Next mm:ss value: clear has priority, then countdown, then set increments.
  always_comb begin
    min_nxt = min_q;
    sec_nxt = sec_q;
    if (load_zero) begin
      min_nxt = '0;
      sec_nxt = '0;
    end else if (dec) begin
      // 00:00 never decrements; the controller leaves RUN before that.
      if (sec_q != '0) begin
        sec_nxt = sec_q - 1'b1;
      end else if (min_q != '0) begin
        min_nxt = min_q - 1'b1;
        sec_nxt = SEC_MAX;
      end
    end else begin
      if (inc_min) begin
        min_nxt = min_inc_wrap(min_q, MIN_TOP);
      end
      if (inc_sec) begin
        sec_nxt = sec_inc_wrap(sec_q);
      end
    end
  end

  // mm:ss registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      sec_q <= '0;
    end else begin
      min_q <= min_nxt;
      sec_q <= sec_nxt;
    end
  end

  assign zero  = (min_nxt == '0) && (sec_nxt == '0);
  assign min_o = min_q;
  assign sec_o = sec_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: countdown-timer controller. Holds a user-set mm:ss value,
// enables the one-second tick generator while counting or alarming, counts
// down to 00:00 and then raises an alarm that self-clears after ALARM_SECS
// ticks or on a button acknowledge.
//
// Build option: define TIMER_CTRL_BLINK_EN to make the alarm output toggle on
// every tick while alarming (starts high, forced low on leaving ALARM);
// undefined, the alarm is a steady high for the whole ALARM state.
//
// state | meaning
// SET   | time editable with min_up/sec_up; start_pb begins a nonzero count
// RUN   | tick generator enabled, each tick removes one second
// PAUSE | time frozen, ticks ignored, start_pb resumes
// ALARM | count reached 00:00, alarm raised, ticks counted toward self-clear
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int MAX_MIN    = 99,
  parameter int ALARM_SECS = 10
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       start_pb,
  input  logic       clear_pb,
  input  logic       min_up,
  input  logic       sec_up,
  input  logic       tick,
  output logic       tick_en,
  output logic [6:0] min_o,
  output logic [5:0] sec_o,
  output logic       alarm,
  output logic [1:0] state_o
);

  // Terminal count: the tick that would bring the counter to ALARM_SECS.
  localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_SECS - 1);

  timer_state_t           state;
  logic [ALARM_CNT_W-1:0] alarm_cnt;

  logic load_zero;
  logic inc_min;
  logic inc_sec;
  logic dec;
  logic nxt_zero;

  // Drive the mm:ss pair from the current state; clear beats everything.
  always_comb begin
    load_zero = 1'b0;
    inc_min   = 1'b0;
    inc_sec   = 1'b0;
    dec       = 1'b0;
    case (state)
      SET: begin
        if (clear_pb) begin
          load_zero = 1'b1;
        end else begin
          inc_min = min_up;
          inc_sec = sec_up;
        end
      end
      RUN: begin
        if (clear_pb) begin
          load_zero = 1'b1;
        end else begin
          dec = tick;
        end
      end
      PAUSE: begin
        load_zero = clear_pb;
      end
      default: begin
      end
    endcase
  end

  timer_mmss_cnt #(
    .MAX_MIN (MAX_MIN)
  ) u_mmss (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .load_zero (load_zero),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .dec       (dec),
    .min_o     (min_o),
    .sec_o     (sec_o),
    .zero      (nxt_zero)
  );

  // Controller FSM with registered tick_en/alarm and the alarm tick counter.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SET;
      tick_en   <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      case (state)
        SET: begin
          // nxt_zero reflects any increment applied this cycle, so RUN is
          // never entered holding 00:00.
          if (!clear_pb && start_pb && !nxt_zero) begin
            state   <= RUN;
            tick_en <= 1'b1;
          end
        end

        RUN: begin
          if (clear_pb) begin
            state   <= SET;
            tick_en <= 1'b0;
          end else if (tick && nxt_zero) begin
            // Reaching 00:00 outranks a simultaneous pause request.
            state     <= ALARM;
            tick_en   <= 1'b1;
            alarm     <= 1'b1;
            alarm_cnt <= '0;
          end else if (start_pb) begin
            state   <= PAUSE;
            tick_en <= 1'b0;
          end
        end

        PAUSE: begin
          if (clear_pb) begin
            state <= SET;
          end else if (start_pb) begin
            state   <= RUN;
            tick_en <= 1'b1;
          end
        end

        ALARM: begin
          if (clear_pb || start_pb) begin
            state     <= SET;
            tick_en   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
          end else if (tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              state     <= SET;
              tick_en   <= 1'b0;
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_cnt + 1'b1;
`ifdef TIMER_CTRL_BLINK_EN
              alarm     <= ~alarm;
`else
              alarm     <= 1'b1;
`endif
            end
          end
        end

        default: begin
          state     <= SET;
          tick_en   <= 1'b0;
          alarm     <= 1'b0;
          alarm_cnt <= '0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
